// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states, bus widths and
// the default inter-byte timeout.
package program_loader_pkg;

  localparam int unsigned BYTE_W                 = 8;
  localparam int unsigned WORD_W                 = 32;
  localparam int unsigned ADDR_W                 = 8;
  localparam int unsigned BYTES_PER_WORD         = WORD_W / BYTE_W;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// master: byte source / memory sink side; slave: the loader itself.
interface program_loader_if;
  import program_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_din;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/program_loader_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// flags expiry once LIMIT cycles have elapsed.
module loader_timeout_counter
  import program_loader_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == W'(LIMIT));

  // Next count: clear wins, otherwise count up and saturate at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a word count and big-endian instruction bytes
// over a valid/ready byte stream and writes them to program memory while
// holding the CPU. Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
// (trailing XOR checksum byte verified before signalling done).
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 8'h00,
  parameter int unsigned       TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  program_loader_if.slave bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t                   state_q, state_d;
  logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;
  logic [1:0]               byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]          words_left_q, words_left_d;
  logic [ADDR_W-1:0]        word_idx_q, word_idx_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [WORD_W-1:0]        din_q, din_d;
  logic                     err_q, err_d;
  logic                     rx_ready;
  logic                     accept;
  logic                     tmo_expired;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]        csum_q, csum_d;
`endif

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign rx_ready = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);
`else
  assign rx_ready = (state_q == ST_COUNT) || (state_q == ST_DATA);
`endif
  assign accept = bus.rx_valid && rx_ready;

  assign bus.rx_ready = rx_ready;
  assign bus.mem_we   = (state_q == ST_WRITE);
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign busy         = (state_q != ST_IDLE);
  assign cpu_hold     = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FINISH);
  assign err          = err_q;

  loader_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (accept || (state_q == ST_IDLE)),
    .en_i      (rx_ready),
    .expired_o (tmo_expired)
  );

  // Next-state and datapath updates for the load session.
  // Bytes assemble in shift_q; mem_din is loaded only with the fourth byte so
  // the write bus stays stable while the following word is being received.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;
    word_idx_d   = word_idx_q;
    addr_d       = addr_q;
    din_d        = din_q;
    err_d        = err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_COUNT;
          err_d      = 1'b0;
          byte_cnt_d = '0;
          word_idx_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_COUNT: begin
        if (accept) begin
          words_left_d = (bus.rx_data == '0) ? 9'd256 : {1'b0, bus.rx_data};
          state_d      = ST_DATA;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          if (byte_cnt_q == LAST_BYTE) begin
            din_d      = {shift_q, bus.rx_data};
            addr_d     = BASE_ADDR + word_idx_q;
            byte_cnt_d = '0;
            state_d    = ST_WRITE;
          end else begin
            shift_d    = {shift_q[WORD_W-2*BYTE_W-1:0], bus.rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        word_idx_d   = word_idx_q + 8'd1;
        words_left_d = words_left_q - 1'b1;
        if (words_left_q == 9'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_FINISH;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (bus.rx_data == csum_q) begin
            state_d = ST_FINISH;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      word_idx_q   <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      err_q        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      word_idx_q   <= word_idx_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      err_q        <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Two instances (BASE_ADDR 00 and FE)
// receive identical stimulus; a reference model derives expected writes.
module tb_program_loader;

  localparam int unsigned TO = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       hold_a, busy_a, done_a, err_a;
  logic       hold_b, busy_b, done_b, err_b;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  program_loader_if ifa ();
  program_loader_if ifb ();

  assign ifa.rx_data  = rx_data;
  assign ifa.rx_valid = rx_valid;
  assign ifb.rx_data  = rx_data;
  assign ifb.rx_valid = rx_valid;

  program_loader #(.BASE_ADDR(8'h00), .TIMEOUT_CYCLES(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifa),
    .cpu_hold(hold_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  program_loader #(.BASE_ADDR(8'hFE), .TIMEOUT_CYCLES(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifb),
    .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  // Observed write streams, done pulses and write-bus stability.
  logic [39:0] qa[$];
  logic [39:0] qb[$];
  logic [39:0] prev_a, prev_b;
  int unsigned ndone_a = 0;
  int unsigned stab_viol = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a = '0;
      prev_b = '0;
    end else begin
      if (ifa.mem_we === 1'b1) qa.push_back({ifa.mem_addr, ifa.mem_din});
      else if ({ifa.mem_addr, ifa.mem_din} !== prev_a) stab_viol++;
      if (ifb.mem_we === 1'b1) qb.push_back({ifb.mem_addr, ifb.mem_din});
      else if ({ifb.mem_addr, ifb.mem_din} !== prev_b) stab_viol++;
      prev_a = {ifa.mem_addr, ifa.mem_din};
      prev_b = {ifb.mem_addr, ifb.mem_din};
      if (done_a === 1'b1) ndone_a++;
    end
  end

  // Reference model: word i goes to base+i (mod 256), bytes big-endian.
  function automatic logic [39:0] exp_entry(input logic [7:0] base, input int unsigned i,
                                            input logic [7:0] d[$]);
    logic [7:0] a;
    a = base + 8'(i);
    return {a, d[4*i], d[4*i+1], d[4*i+2], d[4*i+3]};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int unsigned guard;
    int unsigned gap;
    guard = 0;
    if (rnd) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (ifa.rx_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (ifa.rx_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL handshake: rx_ready=%b, required 1 within 100 cycles", ifa.rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_session(input string name, input logic [7:0] n, input logic [7:0] d[$],
                             input bit rnd, input bit bad_ck, input int start_at);
    int unsigned words, base_a, base_b, nd_a, guard;
    logic [7:0] ck;
    bit ok;
    words = (n == 8'd0) ? 256 : int'(n);
    ok = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ok = !bad_ck;
`endif
    ck = 8'h00;
    base_a = qa.size();
    base_b = qb.size();
    nd_a = ndone_a;
    pulse_start();
    checks++;
    if ({busy_a, hold_a, err_a, ifa.rx_ready} !== 4'b1101) begin
      fails++;
      $display("FAIL %s_start: busy/hold/err/ready=%b, required 1101", name,
               {busy_a, hold_a, err_a, ifa.rx_ready});
    end
    send_byte(n, rnd);
    for (int i = 0; i < int'(4 * words); i++) begin
      ck ^= d[i];
      if (i == start_at) start = 1'b1;
      send_byte(d[i], rnd);
      start = 1'b0;
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_ck ? (ck ^ 8'h01) : ck, rnd);
`endif
    guard = 0;
    while (busy_a === 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if ({busy_a, hold_a} !== 2'b00) begin
      fails++;
      $display("FAIL %s_end: busy/hold=%b, required 00", name, {busy_a, hold_a});
    end
    checks++;
    if (qa.size() - base_a != words) begin
      fails++;
      $display("FAIL %s_count_a: %0d writes, required %0d", name, qa.size() - base_a, words);
    end
    checks++;
    if (qb.size() - base_b != words) begin
      fails++;
      $display("FAIL %s_count_b: %0d writes, required %0d", name, qb.size() - base_b, words);
    end
    for (int unsigned i = 0; i < words; i++) begin
      if (base_a + i < qa.size()) begin
        checks++;
        if (qa[base_a+i] !== exp_entry(8'h00, i, d)) begin
          fails++;
          $display("FAIL %s_word_a[%0d]: addr/data %h, required %h", name, i,
                   qa[base_a+i], exp_entry(8'h00, i, d));
        end
      end
      if (base_b + i < qb.size()) begin
        checks++;
        if (qb[base_b+i] !== exp_entry(8'hFE, i, d)) begin
          fails++;
          $display("FAIL %s_word_b[%0d]: addr/data %h, required %h", name, i,
                   qb[base_b+i], exp_entry(8'hFE, i, d));
        end
      end
    end
    checks++;
    if (ndone_a - nd_a != (ok ? 1 : 0)) begin
      fails++;
      $display("FAIL %s_done: %0d pulses, required %0d", name, ndone_a - nd_a, ok ? 1 : 0);
    end
    checks++;
    if (err_a !== !ok) begin
      fails++;
      $display("FAIL %s_err: err=%b, required %b", name, err_a, !ok);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #12;
    checks++;
    if ({ifa.rx_ready, ifa.mem_we, hold_a, busy_a, done_a, err_a} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: %b, required 000000",
               {ifa.rx_ready, ifa.mem_we, hold_a, busy_a, done_a, err_a});
    end
    checks++;
    if ({ifa.mem_addr, ifa.mem_din, ifb.mem_addr, ifb.mem_din} !== 80'h0) begin
      fails++;
      $display("FAIL reset_bus: %h %h, required 0", ifb.mem_addr, ifb.mem_din);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, hold_a, ifa.rx_ready} !== 3'b000) begin
      fails++;
      $display("FAIL idle_no_start: busy/hold/ready=%b, required 000", {busy_a, hold_a, ifa.rx_ready});
    end
  endtask

  task automatic test_example;
    logic [7:0] d[$];
    logic [63:0] p;
    p = 64'h11223344_AABBCCDD;
    for (int i = 0; i < 8; i++) d.push_back(p[63-8*i -: 8]);
    run_session("example", 8'h02, d, 1'b0, 1'b0, -1);
  endtask

  task automatic test_wrap;
    logic [7:0] d[$];
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    run_session("wrap_steady", 8'h03, d, 1'b0, 1'b0, -1);
    run_session("wrap_toggle", 8'h03, d, 1'b1, 1'b0, -1);
  endtask

  task automatic test_n_zero;
    logic [7:0] d[$];
    for (int i = 0; i < 1024; i++) d.push_back(8'($urandom));
    run_session("n_zero", 8'h00, d, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random;
    logic [7:0] d[$];
    logic [7:0] n;
    repeat (6) begin
      d.delete();
      n = 8'($urandom_range(1, 6));
      for (int i = 0; i < 4 * int'(n); i++) d.push_back(8'($urandom));
      run_session("random", n, d, 1'b1, 1'b0, -1);
    end
  endtask

  task automatic test_start_ignored;
    logic [7:0] d[$];
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    run_session("start_ignored", 8'h03, d, 1'b1, 1'b0, 5);
  endtask

  task automatic test_timeout;
    int unsigned base_a, nd_a, elapsed;
    base_a = qa.size();
    nd_a = ndone_a;
    pulse_start();
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i), 1'b0);
    repeat (TO / 2) @(negedge clk);
    elapsed = TO / 2;
    checks++;
    if ({err_a, busy_a} !== 2'b01) begin
      fails++;
      $display("FAIL timeout_early: err/busy=%b, required 01", {err_a, busy_a});
    end
    while (err_a !== 1'b1 && elapsed < TO + 20) begin
      @(negedge clk);
      elapsed++;
    end
    checks++;
    if (err_a !== 1'b1) begin
      fails++;
      $display("FAIL timeout_err: err=%b, required 1", err_a);
    end
    checks++;
    if (elapsed < TO || elapsed > TO + 2) begin
      fails++;
      $display("FAIL timeout_latency: %0d cycles, required %0d..%0d", elapsed, TO, TO + 2);
    end
    checks++;
    if ({busy_a, hold_a} !== 2'b00) begin
      fails++;
      $display("FAIL timeout_release: busy/hold=%b, required 00", {busy_a, hold_a});
    end
    checks++;
    if (qa.size() - base_a != 1) begin
      fails++;
      $display("FAIL timeout_partial: %0d writes, required 1", qa.size() - base_a);
    end else begin
      checks++;
      if (qa[base_a] !== 40'h00_30313233) begin
        fails++;
        $display("FAIL timeout_word: %h, required 0030313233", qa[base_a]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err_a !== 1'b1 || ndone_a != nd_a) begin
      fails++;
      $display("FAIL timeout_sticky: err=%b done_pulses=%0d, required 1 and 0", err_a, ndone_a - nd_a);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    logic [7:0] d[$];
    d.push_back(8'h01);
    d.push_back(8'h02);
    d.push_back(8'h04);
    d.push_back(8'h08);
    run_session("ck_good", 8'h01, d, 1'b0, 1'b0, -1);
    run_session("ck_bad", 8'h01, d, 1'b0, 1'b1, -1);
  endtask
`endif

  task automatic test_reset_mid;
    int unsigned base_a, base_b;
    logic [7:0] d[$];
    base_a = qa.size();
    base_b = qb.size();
    pulse_start();
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA1 + i), 1'b0);
    checks++;
    if (busy_a !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_busy: busy=%b, required 1", busy_a);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.rx_ready, ifa.mem_we, hold_a, busy_a, done_a, err_a,
         ifb.rx_ready, hold_b, busy_b, err_b} !== 10'b0) begin
      fails++;
      $display("FAIL reset_mid_ctrl: %b, required 0", {ifa.rx_ready, ifa.mem_we, hold_a, busy_a,
               done_a, err_a, ifb.rx_ready, hold_b, busy_b, err_b});
    end
    checks++;
    if ({ifa.mem_addr, ifa.mem_din, ifb.mem_addr, ifb.mem_din} !== 80'h0) begin
      fails++;
      $display("FAIL reset_mid_bus: a=%h/%h b=%h/%h, required 0", ifa.mem_addr, ifa.mem_din,
               ifb.mem_addr, ifb.mem_din);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (qa.size() - base_a != 1 || qb.size() - base_b != 1) begin
      fails++;
      $display("FAIL reset_mid_writes: %0d/%0d, required 1/1", qa.size() - base_a, qb.size() - base_b);
    end
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    run_session("after_reset", 8'h02, d, 1'b1, 1'b0, -1);
  endtask

  task automatic test_stability;
    checks++;
    if (stab_viol != 0) begin
      fails++;
      $display("FAIL bus_stable: %0d changes outside WRITE, required 0", stab_viol);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_example();
    test_wrap();
    test_n_zero();
    test_random();
    test_start_ignored();
    test_timeout();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_stability();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00, first program-memory word address written.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum clk cycles allowed between accepted bytes while loading.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a load session, sampled in IDLE.
REQ-006 SHALL have port rx_data  input  8  incoming byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  program-memory write enable, one-cycle pulse per word.
REQ-010 SHALL have port mem_addr  output  8  program-memory write address.
REQ-011 SHALL have port mem_din  output  32  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  keeps processor PC and register writes frozen while high.
REQ-013 SHALL have ports busy, done, err  output  1 each  session active; one-cycle success pulse; error flag.

Function
REQ-014 SHALL implement FSM states IDLE, COUNT, DATA, WRITE, CHECK, FINISH.
REQ-015 Byte transfer SHALL occur only on a cycle where rx_valid and rx_ready are both 1; rx_ready SHALL be 1 only in COUNT, DATA, CHECK.
REQ-016 IDLE: start=1 -> COUNT next cycle, err cleared, cpu_hold and busy set; start outside IDLE SHALL be ignored.
REQ-017 COUNT: accepted byte N gives word count; N=0 means 256 words; -> DATA.
REQ-018 DATA: bytes assemble big-endian (first byte -> mem_din[31:24], fourth -> [7:0]); after fourth byte -> WRITE.
REQ-019 WRITE: lasts exactly one cycle with mem_we=1, mem_addr=BASE_ADDR+word_index modulo 256, mem_din=assembled word; then DATA if words remain, else CHECK (macro defined) or FINISH.
REQ-020 word_index SHALL start at 0 per session and increment after each WRITE; address wraps 8'hFF -> 8'h00.
REQ-021 FINISH: done=1 for one cycle, cpu_hold and busy deassert on the next edge, -> IDLE.
REQ-022 Inter-byte counter SHALL reset on each accepted byte and on entry to COUNT; reaching TIMEOUT_CYCLES in COUNT/DATA/CHECK SHALL set err, drop cpu_hold/busy, -> IDLE without done.
REQ-023 err SHALL remain 1 until the next accepted start or reset.
REQ-024 mem_addr and mem_din SHALL be held stable outside WRITE; mem_we SHALL be 0 outside WRITE.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_din=0, cpu_hold=0, busy=0, done=0, err=0, counters 0, including mid-session; partially loaded words are not written.

Configuration
REQ-026 Macro PROGRAM_LOADER_CHECKSUM_EN defined: running XOR over all data bytes (count byte excluded); CHECK accepts one byte; match -> FINISH; mismatch -> err=1, -> IDLE, no done (words already written remain).
REQ-027 Macro undefined: no CHECK state reachable, no checksum logic; after last WRITE -> FINISH.

Structure
REQ-028 Shared package SHALL hold FSM state enum, byte/word/address width constants and default TIMEOUT_CYCLES.
REQ-029 One sub-module, loader_timeout_counter (count, clear, expiry flag), SHALL implement the inter-byte timer; rest in program_loader.

Verification
REQ-030 start; bytes 02,11,22,33,44,AA,BB,CC,DD -> writes 32'h11223344@00, 32'hAABBCCDD@01, one done pulse, cpu_hold low after.
REQ-031 BASE_ADDR=8'hFE, N=03 -> writes at FE, FF, 00; rx_valid toggled randomly yields identical words.
REQ-032 Stall 3 bytes into DATA for TIMEOUT_CYCLES -> err=1, no mem_we for partial word, busy=0, no done.
REQ-033 PROGRAM_LOADER_CHECKSUM_EN: N=01, 01,02,04,08, checksum 0F -> done; checksum 0E -> err, no done.
REQ-034 rst_n low during second word -> all outputs 0 immediately; new session after release loads correctly.
REQ-035 start pulsed during DATA -> ignored, session completes unchanged.
